// File: rtl/hdmi_timing_ctrl.sv
// hdmi_timing_ctrl
// Run-time programmable video timing generator for the HDMI pixel pipeline.
// It produces the pixel/line counters, DE, HSYNC, VSYNC and the line/frame
// strobes. New timings go into a shadow set through a valid/ready port and
// are copied into the active set at a frame boundary, so the sink never sees
// a frame that mixes two timings.
module hdmi_timing_ctrl #(
  parameter int   CORDW      = 10,
  parameter int   H_ACTIVE_D = 640,
  parameter int   H_FP_D     = 16,
  parameter int   H_SYNC_D   = 96,
  parameter int   H_BP_D     = 48,
  parameter int   V_ACTIVE_D = 480,
  parameter int   V_FP_D     = 10,
  parameter int   V_SYNC_D   = 2,
  parameter int   V_BP_D     = 33,
  parameter logic SYNC_POL   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_addr,
  input  logic [CORDW-1:0] cfg_data,
  input  logic             cfg_commit,
  output logic             cfg_pending,
  output logic             cfg_err,
  output logic [CORDW-1:0] cx,
  output logic [CORDW-1:0] cy,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line,
  output logic             frame,
  output logic             running
);

  // Totals of four CORDW-bit fields need two extra bits.
  localparam int TW = CORDW + 2;

  typedef logic [TW-1:0]          tot_t;
  typedef logic [CORDW-1:0]       fld_t;
  typedef logic [7:0][CORDW-1:0]  tset_t;

  // Field positions inside a timing set, matching cfg_addr.
  localparam int F_HA  = 0;
  localparam int F_HFP = 1;
  localparam int F_HS  = 2;
  localparam int F_HBP = 3;
  localparam int F_VA  = 4;
  localparam int F_VFP = 5;
  localparam int F_VS  = 6;
  localparam int F_VBP = 7;

  localparam tset_t DEFAULTS = {fld_t'(V_BP_D),   fld_t'(V_SYNC_D),
                                fld_t'(V_FP_D),   fld_t'(V_ACTIVE_D),
                                fld_t'(H_BP_D),   fld_t'(H_SYNC_D),
                                fld_t'(H_FP_D),   fld_t'(H_ACTIVE_D)};

  // Largest legal total: counters must still fit in CORDW bits.
  localparam tot_t TOT_MAX  = tot_t'(2 ** CORDW);
  localparam logic SYNC_OFF = ~SYNC_POL;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  function automatic tot_t sum4(input fld_t a, input fld_t b,
                                input fld_t c, input fld_t d);
    return tot_t'(a) + tot_t'(b) + tot_t'(c) + tot_t'(d);
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nx;

  tset_t  r_act;
  tset_t  r_shd;
  tset_t  w_act_nx;
  tset_t  w_shd_nx;

  logic   r_pending;
  logic   r_err;

  fld_t   r_cx;
  fld_t   r_cy;
  fld_t   w_cx_nx;
  fld_t   w_cy_nx;

  logic   r_de;
  logic   r_hs;
  logic   r_vs;
  logic   r_line;
  logic   r_frame;

  logic   w_wr_acc;
  logic   w_wr_bad;
  logic   w_cm_acc;
  logic   w_cm_bad;
  logic   w_apply;

  logic   w_h_last;
  logic   w_v_last;
  logic   w_frame_end;
  logic   w_run_nx;

  tot_t   w_ht;
  tot_t   w_vt;
  tot_t   w_sh_ht;
  tot_t   w_sh_vt;

  tot_t   w_ncx;
  tot_t   w_ncy;
  tot_t   w_h_ss;
  tot_t   w_h_se;
  tot_t   w_v_ss;
  tot_t   w_v_se;

  logic   w_de_nx;
  logic   w_hs_nx;
  logic   w_vs_nx;
  logic   w_line_nx;
  logic   w_frame_nx;

  // ---------------------------------------------------------------------------
  // Configuration port
  // ---------------------------------------------------------------------------

  // Shadow write: a zero field is rejected; writes are blocked while a commit
  // waits to be applied so the shadow cannot change under it.
  // NOTE: every always_comb target gets a default first; a path that leaves a
  // variable unassigned would otherwise infer a latch.
  always_comb begin
    w_wr_acc = cfg_valid && !r_pending;
    w_wr_bad = w_wr_acc && (cfg_data == '0);
    w_shd_nx = r_shd;
    if (w_wr_acc && !w_wr_bad) begin
      w_shd_nx[cfg_addr] = cfg_data;
    end
  end

  // Shadow totals include a same-cycle write, so a commit issued together
  // with a write validates the updated set.
  assign w_sh_ht = sum4(w_shd_nx[F_HA], w_shd_nx[F_HFP],
                        w_shd_nx[F_HS], w_shd_nx[F_HBP]);
  assign w_sh_vt = sum4(w_shd_nx[F_VA], w_shd_nx[F_VFP],
                        w_shd_nx[F_VS], w_shd_nx[F_VBP]);

  // Commit check and the apply point (frame wrap while running, or the
  // cycle after acceptance when idle).
  always_comb begin
    w_cm_acc = cfg_commit && !r_pending;
    w_cm_bad = w_cm_acc && ((w_sh_ht > TOT_MAX) || (w_sh_vt > TOT_MAX));
    w_apply  = r_pending && ((r_state == S_IDLE) ||
                             ((r_state != S_IDLE) && w_frame_end));
    w_act_nx = w_apply ? r_shd : r_act;
  end

  // Shadow/active timing sets, pending flag and error pulse.
  // NOTE: both timing sets are reset because they must come up holding the
  // parameter defaults; they are a handful of flops, not a memory macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shd     <= DEFAULTS;
      r_act     <= DEFAULTS;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_shd <= w_shd_nx;
      r_act <= w_act_nx;
      r_err <= w_wr_bad || w_cm_bad;
      if (w_apply) begin
        r_pending <= 1'b0;
      end else if (w_cm_acc && !w_cm_bad) begin
        r_pending <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Run control FSM
  // ---------------------------------------------------------------------------

  // Active totals and end-of-line / end-of-frame detection.
  assign w_ht        = sum4(r_act[F_HA], r_act[F_HFP], r_act[F_HS], r_act[F_HBP]);
  assign w_vt        = sum4(r_act[F_VA], r_act[F_VFP], r_act[F_VS], r_act[F_VBP]);
  assign w_h_last    = (tot_t'(r_cx) == (w_ht - tot_t'(1)));
  assign w_v_last    = (tot_t'(r_cy) == (w_vt - tot_t'(1)));
  assign w_frame_end = w_h_last && w_v_last;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state: DRAIN finishes the current frame before parking in IDLE and
  // rejoins RUN seamlessly if en comes back.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (en) w_state_nx = S_RUN;
      S_RUN:   if (!en) w_state_nx = S_DRAIN;
      S_DRAIN: begin
        if (en) begin
          w_state_nx = S_RUN;
        end else if (w_frame_end) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and decoded outputs
  // ---------------------------------------------------------------------------

  // Next counter values: held at zero outside of a run; the first RUN cycle
  // therefore presents (0, 0).
  always_comb begin
    w_run_nx = (w_state_nx != S_IDLE);
    w_cx_nx  = '0;
    w_cy_nx  = '0;
    if ((r_state != S_IDLE) && w_run_nx) begin
      if (w_h_last) begin
        w_cy_nx = w_v_last ? '0 : (r_cy + fld_t'(1));
      end else begin
        w_cx_nx = r_cx + fld_t'(1);
        w_cy_nx = r_cy;
      end
    end
  end

  // Decode from the next counter values and the next active set, so each
  // registered output lines up with the cx/cy it describes.
  always_comb begin
    w_ncx      = tot_t'(w_cx_nx);
    w_ncy      = tot_t'(w_cy_nx);
    w_h_ss     = tot_t'(w_act_nx[F_HA]) + tot_t'(w_act_nx[F_HFP]);
    w_h_se     = w_h_ss + tot_t'(w_act_nx[F_HS]);
    w_v_ss     = tot_t'(w_act_nx[F_VA]) + tot_t'(w_act_nx[F_VFP]);
    w_v_se     = w_v_ss + tot_t'(w_act_nx[F_VS]);
    w_de_nx    = w_run_nx && (w_ncx < tot_t'(w_act_nx[F_HA]))
                          && (w_ncy < tot_t'(w_act_nx[F_VA]));
    w_hs_nx    = w_run_nx && (w_ncx >= w_h_ss) && (w_ncx < w_h_se);
    w_vs_nx    = w_run_nx && (w_ncy >= w_v_ss) && (w_ncy < w_v_se);
    w_line_nx  = w_run_nx && (w_cx_nx == '0);
    w_frame_nx = w_line_nx && (w_ncy == tot_t'(w_act_nx[F_VA]));
  end

  // Counter and timing-output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_de    <= 1'b0;
      r_hs    <= SYNC_OFF;
      r_vs    <= SYNC_OFF;
      r_line  <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_cx    <= w_cx_nx;
      r_cy    <= w_cy_nx;
      r_de    <= w_de_nx;
      r_hs    <= w_hs_nx ? SYNC_POL : SYNC_OFF;
      r_vs    <= w_vs_nx ? SYNC_POL : SYNC_OFF;
      r_line  <= w_line_nx;
      r_frame <= w_frame_nx;
    end
  end

  assign cx          = r_cx;
  assign cy          = r_cy;
  assign de          = r_de;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign line        = r_line;
  assign frame       = r_frame;
  assign running     = (r_state != S_IDLE);
  assign cfg_pending = r_pending;
  assign cfg_ready   = !r_pending;
  assign cfg_err     = r_err;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// tb_hdmi_timing_ctrl
// Directed bench for hdmi_timing_ctrl: a table of config-port vectors plus
// hand-written run sequences checked against a small raster model.
module tb_hdmi_timing_ctrl;

  localparam int CORDW = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_addr;
  logic [CORDW-1:0] cfg_data;
  logic             cfg_commit;
  logic             cfg_pending;
  logic             cfg_err;
  logic [CORDW-1:0] cx;
  logic [CORDW-1:0] cy;
  logic             de;
  logic             hsync;
  logic             vsync;
  logic             line;
  logic             frame;
  logic             running;

  hdmi_timing_ctrl #(.CORDW(CORDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err),
    .cx          (cx),
    .cy          (cy),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .line        (line),
    .frame       (frame),
    .running     (running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Raster model: expected timing and the expected current position.
  int m_ha, m_hfp, m_hs, m_hbp, m_va, m_vfp, m_vs, m_vbp;
  int ecx, ecy;
  int n_frames, n_de;

  typedef struct {
    logic             v;
    logic [2:0]       a;
    logic [CORDW-1:0] d;
    logic             c;
    logic             err;
    logic             pend;
    logic             rdy;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_timing(input int ha, input int hfp, input int hs, input int hbp,
                            input int va, input int vfp, input int vs, input int vbp);
    m_ha = ha;  m_hfp = hfp; m_hs = hs; m_hbp = hbp;
    m_va = va;  m_vfp = vfp; m_vs = vs; m_vbp = vbp;
  endtask

  function automatic int m_ht();
    return m_ha + m_hfp + m_hs + m_hbp;
  endfunction

  function automatic int m_vt();
    return m_va + m_vfp + m_vs + m_vbp;
  endfunction

  function automatic void advance();
    if (ecx == m_ht() - 1) begin
      ecx = 0;
      ecy = (ecy == m_vt() - 1) ? 0 : ecy + 1;
    end else begin
      ecx = ecx + 1;
    end
  endfunction

  // Compare every timing output with the model at the current position.
  task automatic cmp(input string name);
    logic [25:0] got;
    logic [25:0] exp;
    logic e_de, e_hs, e_vs, e_line, e_frame;
    e_de    = (ecx < m_ha) && (ecy < m_va);
    e_hs    = (ecx >= m_ha + m_hfp) && (ecx < m_ha + m_hfp + m_hs);
    e_vs    = (ecy >= m_va + m_vfp) && (ecy < m_va + m_vfp + m_vs);
    e_line  = (ecx == 0);
    e_frame = (ecx == 0) && (ecy == m_va);
    exp = {CORDW'(ecx), CORDW'(ecy), e_de, e_hs, e_vs, e_line, e_frame, 1'b1};
    got = {cx, cy, de, hsync, vsync, line, frame, running};
    check($sformatf("%s@(%0d,%0d)", name, ecx, ecy), 32'(got), 32'(exp));
    if (frame === 1'b1) n_frames++;
    if (de === 1'b1) n_de++;
  endtask

  task automatic start_run();
    en = 1'b1;
    @(posedge clk); #1;
    ecx = 0;
    ecy = 0;
    cmp("start");
  endtask

  // Advance n clocks, checking each; stop early after the first mismatch.
  task automatic track(input int n);
    int e0;
    e0 = n_errors;
    for (int i = 0; i < n; i++) begin
      advance();
      @(posedge clk); #1;
      cmp("track");
      if (n_errors != e0) break;
    end
  endtask

  task automatic track_to(input int x, input int y);
    int guard;
    guard = 0;
    while (!(ecx == x && ecy == y) && guard < 5000) begin
      track(1);
      guard++;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cnt"}, 32'({cx, cy}), 32'd0);
    check({tag, "_out"}, 32'({de, hsync, vsync, line, frame, running}), 32'd0);
    check({tag, "_cfg"}, 32'({cfg_err, cfg_pending, cfg_ready}), 32'b001);
  endtask

  task automatic cfg_step(input logic v, input logic [2:0] a,
                          input logic [CORDW-1:0] d, input logic c);
    cfg_valid  = v;
    cfg_addr   = a;
    cfg_data   = d;
    cfg_commit = c;
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            v     addr  data     commit err   pend  rdy
    vecs[0]  = '{1'b1, 3'd0, 10'd8,  1'b0, 1'b0, 1'b0, 1'b1};  // HA  = 8
    vecs[1]  = '{1'b1, 3'd1, 10'd2,  1'b0, 1'b0, 1'b0, 1'b1};  // HFP = 2
    vecs[2]  = '{1'b1, 3'd2, 10'd3,  1'b0, 1'b0, 1'b0, 1'b1};  // HS  = 3
    vecs[3]  = '{1'b1, 3'd3, 10'd3,  1'b0, 1'b0, 1'b0, 1'b1};  // HBP = 3
    vecs[4]  = '{1'b1, 3'd4, 10'd6,  1'b0, 1'b0, 1'b0, 1'b1};  // VA  = 6
    vecs[5]  = '{1'b1, 3'd5, 10'd2,  1'b0, 1'b0, 1'b0, 1'b1};  // VFP = 2
    vecs[6]  = '{1'b1, 3'd6, 10'd0,  1'b0, 1'b1, 1'b0, 1'b1};  // VS = 0 rejected
    vecs[7]  = '{1'b0, 3'd0, 10'd0,  1'b0, 1'b0, 1'b0, 1'b1};  // err is one cycle
    vecs[8]  = '{1'b1, 3'd7, 10'd2,  1'b1, 1'b0, 1'b1, 1'b0};  // VBP = 2 + commit
    vecs[9]  = '{1'b1, 3'd0, 10'd5,  1'b1, 1'b0, 1'b0, 1'b1};  // ignored; idle apply
    vecs[10] = '{1'b0, 3'd0, 10'd0,  1'b0, 1'b0, 1'b0, 1'b1};

    rst_n      = 1'b0;
    en         = 1'b0;
    cfg_valid  = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    cfg_commit = 1'b0;

    // Reset values.
    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_hold", 32'({running, cx, de}), 32'd0);

    // Default 800x525 timing over the first lines.
    set_timing(640, 16, 96, 48, 480, 10, 2, 33);
    n_frames = 0;
    n_de     = 0;
    start_run();
    track(1700);
    check("de_count_defaults", 32'(n_de), 32'd1381);

    // Pending commit discarded by reset mid-frame.
    cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = 10'd8;
    track(1);
    cfg_valid = 1'b0; cfg_commit = 1'b1;
    track(1);
    cfg_commit = 1'b0;
    check("pend_before_reset", 32'({cfg_pending, cfg_ready, cfg_err}), 32'b100);
    track(5);
    #3;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check_reset("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Committing the reset shadow from IDLE applies the next cycle.
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    check("idle_commit", 32'({cfg_pending, cfg_ready, cfg_err}), 32'b100);
    @(posedge clk); #1;
    check("idle_apply", 32'({cfg_pending, cfg_ready}), 32'b01);
    n_de = 0;
    start_run();
    track(810);
    check("de_count_restored", 32'(n_de), 32'd651);
    #3;
    rst_n = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Config vectors applied from IDLE.
    for (int i = 0; i < NV; i++) begin
      cfg_valid  = vecs[i].v;
      cfg_addr   = vecs[i].a;
      cfg_data   = vecs[i].d;
      cfg_commit = vecs[i].c;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i),
            32'({cfg_err, cfg_pending, cfg_ready, running, de}),
            32'({vecs[i].err, vecs[i].pend, vecs[i].rdy, 2'b00}));
    end
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;

    // Small timing 16x12: two full frames.
    set_timing(8, 2, 3, 3, 6, 2, 2, 2);
    n_frames = 0;
    n_de     = 0;
    start_run();
    track(383);
    check("frames_small", 32'(n_frames), 32'd2);
    check("de_count_small", 32'(n_de), 32'd96);

    // Mid-frame horizontal change, applied at the next (0,0).
    track(49);
    cfg_valid = 1'b1;
    cfg_addr = 3'd0; cfg_data = 10'd4; track(1);
    cfg_addr = 3'd1; cfg_data = 10'd1; track(1);
    cfg_addr = 3'd2; cfg_data = 10'd2; track(1);
    cfg_addr = 3'd3; cfg_data = 10'd1; track(1);
    cfg_valid  = 1'b0;
    cfg_commit = 1'b1;
    track(1);
    cfg_commit = 1'b0;
    check("pend_set", 32'({cfg_pending, cfg_ready, cfg_err}), 32'b100);
    track_to(15, 11);
    check("pend_hold_to_end", 32'({cfg_pending, cfg_ready}), 32'b10);
    set_timing(4, 1, 2, 1, 6, 2, 2, 2);
    ecx = 7;
    ecy = 11;
    n_frames = 0;
    n_de     = 0;
    track(1);
    check("pend_clear", 32'({cfg_pending, cfg_ready}), 32'b01);
    track(95);
    check("frames_new", 32'(n_frames), 32'd1);
    check("de_count_new", 32'(n_de), 32'd24);

    // HT = 1000+16+96+48 = 1160 > 1024: commit rejected, timing unchanged.
    cfg_valid = 1'b1;
    cfg_addr = 3'd0; cfg_data = 10'd1000; track(1);
    cfg_addr = 3'd1; cfg_data = 10'd16;   track(1);
    cfg_addr = 3'd2; cfg_data = 10'd96;   track(1);
    cfg_addr = 3'd3; cfg_data = 10'd48;   track(1);
    cfg_valid  = 1'b0;
    cfg_commit = 1'b1;
    track(1);
    cfg_commit = 1'b0;
    check("ovf_err", 32'({cfg_err, cfg_pending}), 32'b10);
    track(1);
    check("err_one_pulse", 32'(cfg_err), 32'd0);

    // Drain with en returning mid-drain, then drain to IDLE.
    track_to(0, 4);
    en = 1'b0;
    track_to(0, 7);
    en = 1'b1;
    track_to(7, 11);
    track_to(0, 2);
    en = 1'b0;
    track_to(7, 11);
    @(posedge clk); #1;
    check("drain_idle", 32'({cx, cy, de, hsync, vsync, line, frame, running}), 32'd0);
    @(posedge clk); #1;
    check("idle_stays", 32'({cx, cy, de, running}), 32'd0);

    // Total boundary: 1000+8+8+8 = 1024 accepted, 1025 rejected.
    cfg_step(1'b1, 3'd1, 10'd8, 1'b0);
    cfg_step(1'b1, 3'd2, 10'd8, 1'b0);
    cfg_step(1'b1, 3'd3, 10'd8, 1'b1);
    check("commit_1024_ok", 32'({cfg_err, cfg_pending}), 32'b01);
    cfg_step(1'b0, 3'd0, 10'd0, 1'b0);
    check("apply_1024", 32'(cfg_pending), 32'd0);
    cfg_step(1'b1, 3'd3, 10'd9, 1'b1);
    check("commit_1025_err", 32'({cfg_err, cfg_pending}), 32'b10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
